simd_result_collector: RTL

Write-back end of the SIMD datapath: receives per-cycle lane results from `simd_top_level` and packs lane 0 and lane 1 into 64-bit words. Words are buffered in a small FIFO and handed to the memory controller over a valid/ready handshake. The block counts results against a programmed job length and flags the last word and job completion, mirroring the operand side that feeds `mc_data_in_opa`/`mc_data_in_opb`.

---
 rtl/simd_result_collector_if.sv | 25 ++
 rtl/simd_result_collector.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/simd_result_collector_if.sv
// Result stream from the SIMD collector to the memory controller.
// The collector is the master and the memory controller is the slave.
interface simd_result_collector_if;
   logic        mc_result_valid;
   logic        mc_result_ready;
   logic [63:0] mc_data_out_res;
   logic [63:0] mc_data_out_extra;
   logic        mc_result_last;

   modport master (
      output mc_result_valid,
      output mc_data_out_res,
      output mc_data_out_extra,
      output mc_result_last,
      input  mc_result_ready
   );

   modport slave (
      input  mc_result_valid,
      input  mc_data_out_res,
      input  mc_data_out_extra,
      input  mc_result_last,
      output mc_result_ready
   );
endinterface

// File: rtl/simd_result_collector.sv
// Packs lane 0/1 SIMD results into 64-bit words, buffers them in a show-ahead
// FIFO and streams them to the memory controller with job-length tracking.
module simd_result_collector #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [5:0]                     data_size,
   input  logic                           res_valid,
   input  logic [31:0]                    out_procc0,
   input  logic [31:0]                    out_procc1,
   input  logic [31:0]                    out_extra_procc0,
   input  logic [31:0]                    out_extra_procc1,
   output logic                           res_ready,
   simd_result_collector_if.master        mc,
   output logic                           busy,
   output logic                           done,
   output logic                           overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

   state_t          state_reg;
   logic [5:0]      job_len_reg;
   logic [5:0]      acc_cnt_reg;
   logic [5:0]      pop_cnt_reg;
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic            busy_reg;
   logic            done_reg;
   logic            overflow_reg;

   logic [63:0]     res_mem   [FIFO_DEPTH];
   logic [63:0]     extra_mem [FIFO_DEPTH];

   logic [31:0]     lane_res   [2];
   logic [31:0]     lane_extra [2];
   logic [63:0]     push_res;
   logic [63:0]     push_extra;

   logic            head_valid;
   logic            head_last;
   logic            push;
   logic            pop;

   assign lane_res[0]   = out_procc0;
   assign lane_res[1]   = out_procc1;
   assign lane_extra[0] = out_extra_procc0;
   assign lane_extra[1] = out_extra_procc1;

   // Lane n occupies bits [32n+31:32n] of each packed word.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         assign push_res[gi*32 +: 32]   = lane_res[gi];
         assign push_extra[gi*32 +: 32] = lane_extra[gi];
      end
   endgenerate

   // Ready depends only on registered state, never on mc_result_ready.
   assign res_ready  = (state_reg == S_COLLECT) && (count_reg != FULL_CNT);
   assign head_valid = (count_reg != '0);
   assign head_last  = head_valid && (pop_cnt_reg == (job_len_reg - 6'd1));
   assign push       = res_valid && res_ready;
   assign pop        = head_valid && mc.mc_result_ready;

   assign mc.mc_result_valid   = head_valid;
   assign mc.mc_result_last    = head_last;
   assign mc.mc_data_out_res   = head_valid ? res_mem[rd_ptr_reg]   : '0;
   assign mc.mc_data_out_extra = head_valid ? extra_mem[rd_ptr_reg] : '0;

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign overflow = overflow_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         res_mem[wr_ptr_reg]   <= push_res;
         extra_mem[wr_ptr_reg] <= push_extra;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         job_len_reg  <= '0;
         acc_cnt_reg  <= '0;
         pop_cnt_reg  <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop) begin
            rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            pop_cnt_reg <= pop_cnt_reg + 6'd1;
         end

         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase

         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  job_len_reg  <= data_size;
                  acc_cnt_reg  <= '0;
                  pop_cnt_reg  <= '0;
                  overflow_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  if (data_size == 6'd0) begin
                     state_reg <= S_DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= S_COLLECT;
                  end
               end
            end
            S_COLLECT: begin
               if (res_valid && !res_ready) overflow_reg <= 1'b1;
               if (push) begin
                  acc_cnt_reg <= acc_cnt_reg + 6'd1;
                  if ((acc_cnt_reg + 6'd1) == job_len_reg) state_reg <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && head_last) begin
                  state_reg <= S_DONE;
                  done_reg  <= 1'b1;
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule
